// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StOwn,
    StRelease
  } arb_state_e;

  // Owner encoding, also the value presented on sel.
  localparam logic OWN_W = 1'b0;
  localparam logic OWN_R = 1'b1;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Engine-side and pad-side signals of the bus arbiter, bundled.
interface i2c_bus_arbiter_if;

  logic req_w;
  logic req_r;
  logic done_w;
  logic done_r;
  logic scl_w;
  logic sda_w;
  logic scl_r;
  logic sda_r;
  logic scl_i;
  logic sda_i;

  logic gnt_w;
  logic gnt_r;
  logic sel;
  logic scl_o;
  logic sda_o;
  logic busy;
  logic err_timeout;

  // Arbiter side.
  modport master (
    input  req_w, req_r, done_w, done_r, scl_w, sda_w, scl_r, sda_r, scl_i, sda_i,
    output gnt_w, gnt_r, sel, scl_o, sda_o, busy, err_timeout
  );

  // Engine / pad side.
  modport slave (
    output req_w, req_r, done_w, done_r, scl_w, sda_w, scl_r, sda_r, scl_i, sda_i,
    input  gnt_w, gnt_r, sel, scl_o, sda_o, busy, err_timeout
  );

endinterface

// File: rtl/i2c_bus_free_det.sv
// Counts consecutive cycles with SCL and SDA both high while enabled.
module i2c_bus_free_det
  import i2c_arb_pkg::*;
#(
  parameter int unsigned BUS_FREE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic scl_i,
  input  logic sda_i,
  output logic free
);

  localparam logic [CNT_W-1:0] FreeLast = CNT_W'(BUS_FREE_CYC - 1);

  logic             bus_high;
  logic [CNT_W-1:0] free_cnt_q;

  assign bus_high = scl_i & sda_i;

  // Free-interval counter: cleared when disabled or on any low sample.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      free_cnt_q <= '0;
    end else if (bus_high) begin
      if (free_cnt_q != FreeLast) begin
        free_cnt_q <= free_cnt_q + 1'b1;
      end
    end else begin
      free_cnt_q <= '0;
    end
  end

  // The sample completing the interval must itself be high.
  assign free = en & bus_high & (free_cnt_q == FreeLast);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of the shared open-drain I2C bus between write and read engines.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned BUS_FREE_CYC = 8,
  parameter int unsigned TIMEOUT_CYC  = 65535
) (
  input  logic              clk,
  input  logic              rst,
  i2c_bus_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] ToLast = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e       state_q;
  logic             winner_q;
  logic             last_owner_q;
  logic [CNT_W-1:0] to_cnt_q;

  logic gnt_w_q;
  logic gnt_r_q;
  logic sel_q;
  logic scl_o_q;
  logic sda_o_q;
  logic busy_q;
  logic err_timeout_q;

  logic free;
  logic pick;
  logic own_req;
  logic own_done;
  logic own_scl;
  logic own_sda;

  i2c_bus_free_det #(
    .BUS_FREE_CYC(BUS_FREE_CYC)
  ) u_free_det (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == StGuard),
    .scl_i(bus.scl_i),
    .sda_i(bus.sda_i),
    .free (free)
  );

  // Steer the latched winner's signals; the other engine is never looked at.
  always_comb begin
    own_req  = bus.req_w;
    own_done = bus.done_w;
    own_scl  = bus.scl_w;
    own_sda  = bus.sda_w;
    if (winner_q == OWN_R) begin
      own_req  = bus.req_r;
      own_done = bus.done_r;
      own_scl  = bus.scl_r;
      own_sda  = bus.sda_r;
    end
  end

  // Round-robin pick: on a tie the engine not served last wins.
  always_comb begin
    pick = bus.req_r ? OWN_R : OWN_W;
    if (bus.req_w && bus.req_r) begin
      pick = (last_owner_q == OWN_R) ? OWN_W : OWN_R;
    end
  end

  // Arbitration FSM with watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      winner_q      <= OWN_W;
      last_owner_q  <= OWN_R;
      to_cnt_q      <= '0;
      gnt_w_q       <= 1'b0;
      gnt_r_q       <= 1'b0;
      sel_q         <= OWN_W;
      scl_o_q       <= 1'b1;
      sda_o_q       <= 1'b1;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= 1'b0;
      scl_o_q       <= 1'b1;
      sda_o_q       <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (bus.req_w || bus.req_r) begin
            winner_q <= pick;
            state_q  <= StGuard;
            busy_q   <= 1'b1;
          end
        end
        StGuard: begin
          if (!own_req) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (free) begin
            state_q  <= StOwn;
            gnt_w_q  <= (winner_q == OWN_W);
            gnt_r_q  <= (winner_q == OWN_R);
            sel_q    <= winner_q;
            to_cnt_q <= '0;
          end
        end
        StOwn: begin
          if (own_done || !own_req || (to_cnt_q == ToLast)) begin
            state_q       <= StRelease;
            gnt_w_q       <= 1'b0;
            gnt_r_q       <= 1'b0;
            last_owner_q  <= winner_q;
            // Only a watchdog expiry flags an error; done wins a tie.
            err_timeout_q <= !own_done && own_req;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            scl_o_q  <= own_scl;
            sda_o_q  <= own_sda;
          end
        end
        StRelease: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_w       = gnt_w_q;
  assign bus.gnt_r       = gnt_r_q;
  assign bus.sel         = sel_q;
  assign bus.scl_o       = scl_o_q;
  assign bus.sda_o       = sda_o_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_timeout_q;

endmodule
